// File: rtl/dvi_tmds_pkg.sv
// dvi_tmds_pkg: shared constants, pixel record and stage-1 helpers for the
// three-channel TMDS encoder. The HDMI preamble/guard-band constants are only
// consumed when the encoder is built with TMDS_HDMI_PREAMBLE_EN defined.
package dvi_tmds_pkg;

  // Smallest running-disparity counter that can hold the full signed swing
  localparam int DISP_W_MIN = 5;

  // HDMI video preamble and leading guard band lengths, in pixels
  localparam int PREAMBLE_LEN  = 8;
  localparam int GUARD_LEN     = 2;
  localparam int LOOKAHEAD_LEN = PREAMBLE_LEN + GUARD_LEN;

  // Control-period tokens indexed by {C1,C0}
  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  // Video leading guard band symbols per channel
  localparam logic [9:0] GUARD_CH0 = 10'h2CC;
  localparam logic [9:0] GUARD_CH1 = 10'h133;
  localparam logic [9:0] GUARD_CH2 = 10'h2CC;

  // One pixel as it travels through the look-ahead delay line
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Number of set bits in a byte (0..8)
  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Control token for a {C1,C0} pair
  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] tok;
    case ({c1, c0})
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

  // Transition-minimising first stage: XNOR chain for bit-heavy bytes, XOR
  // chain otherwise; bit 8 records which chain was used (1 = XOR)
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/tmds_chan_enc.sv
// tmds_chan_enc: one TMDS channel. Stage 1 registers the transition-minimised
// word with DE/C0/C1/guard; stage 2 balances DC against a per-channel signed
// running-disparity counter, or emits a control token / guard symbol.
module tmds_chan_enc
  import dvi_tmds_pkg::*;
#(
  parameter int         DISP_W    = DISP_W_MIN,
  parameter logic [9:0] GUARD_SYM = GUARD_CH0
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst,
  input  logic       I_de,
  input  logic       I_c0,
  input  logic       I_c1,
  input  logic       I_guard,
  input  logic [7:0] I_data,
  output logic [9:0] O_tmds
);

  logic [8:0] q_m_r;
  logic       de_r;
  logic       c0_r;
  logic       c1_r;
  logic       guard_r;

  logic signed [DISP_W-1:0] cnt_r;
  logic signed [DISP_W-1:0] cnt_next;
  logic signed [DISP_W-1:0] ones_s;
  logic signed [DISP_W-1:0] zeros_s;
  logic signed [DISP_W-1:0] diff_s;
  logic signed [DISP_W-1:0] two_s;
  logic [3:0]               n1q;
  logic [9:0]               sym_next;

  // Stage 1: transition-minimise the byte and delay the control flags with it
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      q_m_r   <= '0;
      de_r    <= 1'b0;
      c0_r    <= 1'b0;
      c1_r    <= 1'b0;
      guard_r <= 1'b0;
    end else begin
      q_m_r   <= transition_min(I_data);
      de_r    <= I_de;
      c0_r    <= I_c0;
      c1_r    <= I_c1;
      guard_r <= I_guard;
    end
  end

  // Stage 2 decision: pick polarity of q_m[7:0] to pull disparity toward zero
  always_comb begin
    n1q      = popcount8(q_m_r[7:0]);
    ones_s   = $signed(DISP_W'(n1q));
    zeros_s  = $signed(DISP_W'(4'd8 - n1q));
    diff_s   = ones_s - zeros_s;
    two_s    = $signed(DISP_W'(2));
    sym_next = {1'b0, q_m_r};
    cnt_next = cnt_r;
    if ((cnt_r == '0) || (n1q == 4'd4)) begin
      if (q_m_r[8]) begin
        sym_next = {1'b0, 1'b1, q_m_r[7:0]};
        cnt_next = cnt_r + diff_s;
      end else begin
        sym_next = {1'b1, 1'b0, ~q_m_r[7:0]};
        cnt_next = cnt_r - diff_s;
      end
    end else if ((!cnt_r[DISP_W-1] && (n1q > 4'd4)) ||
                 ( cnt_r[DISP_W-1] && (n1q < 4'd4))) begin
      sym_next = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_next = q_m_r[8] ? (cnt_r + two_s - diff_s) : (cnt_r - diff_s);
    end else begin
      sym_next = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_next = q_m_r[8] ? (cnt_r + diff_s) : (cnt_r + diff_s - two_s);
    end
  end

  // Stage 2 register: guard symbol beats control token beats video data
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      O_tmds <= CTRL_TOKEN_00;
      cnt_r  <= '0;
    end else if (guard_r) begin
      O_tmds <= GUARD_SYM;
      cnt_r  <= '0;
    end else if (!de_r) begin
      O_tmds <= ctrl_token(c1_r, c0_r);
      cnt_r  <= '0;
    end else begin
      O_tmds <= sym_next;
      cnt_r  <= cnt_next;
    end
  end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder: three-channel DVI TMDS encoder (blue+HS/VS on ch0, green
// on ch1, red on ch2), two-cycle latency. Defining TMDS_HDMI_PREAMBLE_EN adds a
// ten-pixel delay line whose look-ahead inserts the HDMI video preamble and
// leading guard band before each active line (latency becomes twelve).
module dvi_tmds_encoder
  import dvi_tmds_pkg::*;
#(
  parameter int DISP_W = DISP_W_MIN
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst,
  input  logic       I_de,
  input  logic       I_hs,
  input  logic       I_vs,
  input  logic [7:0] I_data_r,
  input  logic [7:0] I_data_g,
  input  logic [7:0] I_data_b,
  output logic [9:0] O_tmds_ch0,
  output logic [9:0] O_tmds_ch1,
  output logic [9:0] O_tmds_ch2
);

  logic       enc_de;
  logic       enc_hs;
  logic       enc_vs;
  logic [7:0] enc_r;
  logic [7:0] enc_g;
  logic [7:0] enc_b;
  logic       enc_guard;
  logic       enc_ch1_c0;

`ifdef TMDS_HDMI_PREAMBLE_EN
  pixel_t dly [LOOKAHEAD_LEN];
  pixel_t oldest;
  logic   guard_hit;
  logic   pre_hit;

  // Delay line: dly[0] is the newest pixel, dly[LOOKAHEAD_LEN-1] feeds the encoders
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      for (int k = 0; k < LOOKAHEAD_LEN; k++) begin
        dly[k] <= '0;
      end
    end else begin
      dly[0] <= '{de: I_de, hs: I_hs, vs: I_vs, r: I_data_r, g: I_data_g, b: I_data_b};
      for (int k = 1; k < LOOKAHEAD_LEN; k++) begin
        dly[k] <= dly[k-1];
      end
    end
  end

  assign oldest = dly[LOOKAHEAD_LEN-1];

  // Look-ahead: pixel n+m sits in dly[LOOKAHEAD_LEN-1-m]; n+LOOKAHEAD_LEN is the live input
  always_comb begin
    guard_hit = 1'b0;
    for (int m = 1; m <= GUARD_LEN; m++) begin
      guard_hit = guard_hit | dly[LOOKAHEAD_LEN-1-m].de;
    end
    pre_hit = I_de;
    for (int m = GUARD_LEN + 1; m < LOOKAHEAD_LEN; m++) begin
      pre_hit = pre_hit | dly[LOOKAHEAD_LEN-1-m].de;
    end
  end

  assign enc_de     = oldest.de;
  assign enc_hs     = oldest.hs;
  assign enc_vs     = oldest.vs;
  assign enc_r      = oldest.r;
  assign enc_g      = oldest.g;
  assign enc_b      = oldest.b;
  assign enc_guard  = !oldest.de && guard_hit;
  assign enc_ch1_c0 = !oldest.de && !guard_hit && pre_hit;
`else
  assign enc_de     = I_de;
  assign enc_hs     = I_hs;
  assign enc_vs     = I_vs;
  assign enc_r      = I_data_r;
  assign enc_g      = I_data_g;
  assign enc_b      = I_data_b;
  assign enc_guard  = 1'b0;
  assign enc_ch1_c0 = 1'b0;
`endif

  tmds_chan_enc #(
    .DISP_W    (DISP_W),
    .GUARD_SYM (GUARD_CH0)
  ) u_ch0 (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_de      (enc_de),
    .I_c0      (enc_hs),
    .I_c1      (enc_vs),
    .I_guard   (enc_guard),
    .I_data    (enc_b),
    .O_tmds    (O_tmds_ch0)
  );

  tmds_chan_enc #(
    .DISP_W    (DISP_W),
    .GUARD_SYM (GUARD_CH1)
  ) u_ch1 (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_de      (enc_de),
    .I_c0      (enc_ch1_c0),
    .I_c1      (1'b0),
    .I_guard   (enc_guard),
    .I_data    (enc_g),
    .O_tmds    (O_tmds_ch1)
  );

  tmds_chan_enc #(
    .DISP_W    (DISP_W),
    .GUARD_SYM (GUARD_CH2)
  ) u_ch2 (
    .I_pxl_clk (I_pxl_clk),
    .I_rst     (I_rst),
    .I_de      (enc_de),
    .I_c0      (1'b0),
    .I_c1      (1'b0),
    .I_guard   (enc_guard),
    .I_data    (enc_r),
    .O_tmds    (O_tmds_ch2)
  );

endmodule
